data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Responder side of the CPU data-SRAM interface: accepts the enable/byte-write-enable/address/write-data requests issued by the execute stage and returns read data one cycle later for the memory stage. Holds a byte-writable synchronous RAM plus a small memory-mapped register window (LED, numeric display, switch input, free-running timer). It sits in the SoC top beside the CPU core and replaces a bare RAM macro on the data port.

## Interface
- RAM_AW, 14, word-address width of the RAM (2^RAM_AW words; default 64 KiB)
- MMIO_HI, 16'hbfaf, value of addr[31:16] that selects the register window
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- data_sram_en  in  1  request valid this cycle (read or write)
- data_sram_wen  in  4  byte write enables, bit i selects wdata[8i+7:8i]; 4'h0 with en=1 is a read
- data_sram_addr  in  32  byte address; bits [1:0] ignored
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, registered
- led  out  16  LED register
- num  out  32  numeric-display register
- switch  in  8  asynchronous board switches

## Operation
- Decode: addr[31:16]==MMIO_HI selects MMIO; otherwise RAM, word index addr[RAM_AW+1:2]; upper address bits ignored (RAM aliases/wraps).
- MMIO offsets (addr[15:0]): 16'hf000 LED (RW, bits [15:0]; bytes 2–3 of a write ignored, read upper 16 as 0); 16'hf010 NUM (RW, 32 bits); 16'hf020 SWITCH (RO, bits [7:0], upper 0); 16'he000 TIMER (RW, 32 bits). Any other MMIO offset: read returns 0, write ignored.
- Writes (en=1, wen!=0): only enabled bytes change, in RAM or in the selected register. Write to SWITCH ignored.
- Reads (en=1, wen=0): rdata loaded with the addressed word at the edge.
- Write with en=1 and wen!=0 also loads rdata with the pre-write word (read-first); the CPU ignores it.
- en=0: rdata holds its previous value; no state other than TIMER and switch synchronizer changes.
- TIMER: increments by 1 (mod 2^32) every cycle. A write replaces the enabled bytes of the current value (no increment that cycle); next cycle increments from the written value.
- SWITCH: two-flop synchronizer; reads return the second stage.

## Timing
- Reset values: rdata=0, led=0, num=0, TIMER=0, synchronizer flops=0. RAM contents are not reset.
- Read latency: exactly 1 cycle; request at edge N, data_sram_rdata valid after edge N and held until next request.
- Write latency: state updated at the request edge; a read of the same address in the next cycle returns the new value.
- Back-to-back requests every cycle supported; no stall signal, responder is always ready.
- Read of TIMER returns the value before that edge's increment (T at request → rdata=T).
- Read-during-write same cycle impossible (single port); write-then-read next cycle sees new data.
- Reset asserted during a request: request dropped, rdata=0, no RAM write performed.
- Switch change visible to reads 2 cycles after it is sampled stable at an edge.

## Test plan
- RAM word write/read: write 32'hdeadbeef, wen=4'hf, addr 32'h0000_0100; next cycle read 32'h100 → rdata 32'hdeadbeef one cycle later; en=0 for 3 cycles → rdata unchanged.
- Byte enables: after above, write 32'h1122_3344 wen=4'b0101 to 32'h100 → read returns 32'hde22be44.
- Aliasing: with RAM_AW=14, write 32'h5a5a5a5a to 32'h0001_0100, read 32'h0000_0100 → 32'h5a5a5a5a.
- MMIO: write 32'hffff_abcd to 32'hbfaf_f000 → led=16'habcd, read → 32'h0000_abcd; write num 32'h12345678 → num output updated same edge; switch=8'h3c held → read 32'hbfaf_f020 ≥2 cycles later → 32'h0000_003c; read 32'hbfaf_f0f0 → 0.
- Timer: after reset, read TIMER at cycle 10 post-reset → 10; write 32'hffff_fffe wen=4'hf, read 2 cycles later → 32'h0000_0000 (wrap).
- Reset mid-operation: issue write to 32'h200 and read in reset cycle → RAM at 32'h200 unchanged, rdata=0, led=0, num=0, TIMER=0.

Source files
------------

// File: rtl/data_sram_resp.sv
// CPU data-SRAM responder: byte-writable RAM plus LED/NUM/SWITCH/TIMER register window.
// Read data is registered, one cycle after the request; always ready, so it never stalls the CPU.
module data_sram_resp #(
  parameter int unsigned RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num,
  input  logic [7:0]  switch
);

  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_NUM   = 16'hf010;
  localparam logic [15:0] OFF_SW    = 16'hf020;
  localparam logic [15:0] OFF_TIMER = 16'he000;

  logic [31:0] mem [2**RAM_AW];

  logic [31:0] rdata_q;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic              mmio_sel;
  logic [15:0]       mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_req;
  logic              ram_we;
  logic [31:0]       mmio_rd;
  logic [31:0]       led_merged;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI);
  assign mmio_off = data_sram_addr[15:0];
  assign ram_idx  = data_sram_addr[RAM_AW+1:2];
  assign wr_req   = data_sram_en && (data_sram_wen != 4'h0);
  assign ram_we   = wr_req && !mmio_sel && !reset;

  // Timer reads see the value held before this edge's increment.
  always_comb begin
    mmio_rd = 32'h0;
    case (mmio_off)
      OFF_LED:   mmio_rd = {16'h0, led_q};
      OFF_NUM:   mmio_rd = num_q;
      OFF_SW:    mmio_rd = {24'h0, sw_sync_q};
      OFF_TIMER: mmio_rd = timer_q;
      default:   mmio_rd = 32'h0;
    endcase
  end

  always_comb begin
    led_merged = byte_merge({16'h0, led_q}, data_sram_wdata, {2'b00, data_sram_wen[1:0]});
    led_d      = led_q;
    num_d      = num_q;
    timer_d    = timer_q + 32'd1;
    if (wr_req && mmio_sel) begin
      case (mmio_off)
        OFF_LED:   led_d   = led_merged[15:0];
        OFF_NUM:   num_d   = byte_merge(num_q, data_sram_wdata, data_sram_wen);
        OFF_TIMER: timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      num_q     <= 32'h0;
      timer_q   <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      if (data_sram_en) rdata_q <= mmio_sel ? mmio_rd : mem[ram_idx];
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM contents survive reset; only the write itself is suppressed.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem[ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num             = num_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed plus randomized checks of data_sram_resp against a transaction-level reference model.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num;
  logic [7:0]  switch;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] mmem [int];
  logic [31:0] m_rdata;
  logic        m_known;
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [7:0]  sw_hist [2];

  data_sram_resp #(.RAM_AW(14), .MMIO_HI(16'hbfaf)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .num             (num),
    .switch          (switch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // One clock edge: drive a request, advance the model, then compare outputs.
  task automatic step(input logic rst, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic        mm;
    logic [15:0] off;
    int          idx;
    logic [31:0] oldt, rd, w;
    reset = rst; data_sram_en = en; data_sram_wen = wen;
    data_sram_addr = addr; data_sram_wdata = wd;
    mm  = (addr[31:16] == 16'hbfaf);
    off = addr[15:0];
    idx = int'(addr[15:2]);
    if (rst) begin
      m_rdata = 0; m_known = 1'b1; m_led = 0; m_num = 0; m_timer = 0;
      sw_hist[0] = 0; sw_hist[1] = 0;
    end else begin
      oldt    = m_timer;
      m_timer = oldt + 1;
      if (en) begin
        rd = 0;
        if (mm) begin
          m_known = 1'b1;
          if (off == 16'hf000) rd = {16'h0, m_led};
          else if (off == 16'hf010) rd = m_num;
          else if (off == 16'hf020) rd = {24'h0, sw_hist[1]};
          else if (off == 16'he000) rd = oldt;
        end else begin
          m_known = mmem.exists(idx);
          if (m_known) rd = mmem[idx];
        end
        m_rdata = rd;
        if (wen != 0) begin
          if (mm) begin
            if (off == 16'hf000) begin
              w = merge({16'h0, m_led}, wd, {2'b00, wen[1:0]});
              m_led = w[15:0];
            end else if (off == 16'hf010) m_num = merge(m_num, wd, wen);
            else if (off == 16'he000) m_timer = merge(oldt, wd, wen);
          end else begin
            w = mmem.exists(idx) ? mmem[idx] : 32'h0;
            mmem[idx] = merge(w, wd, wen);
          end
        end
      end
      sw_hist[1] = sw_hist[0];
      sw_hist[0] = switch;
    end
    @(posedge clk);
    #1;
    if (m_known) check("rdata", data_sram_rdata, m_rdata);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("num", num, m_num);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b0, 1'b1, be, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, 4'h0, a, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [15:0] hi;
    logic [15:0] offs [5];
    offs[0] = 16'hf000; offs[1] = 16'hf010; offs[2] = 16'hf020;
    offs[3] = 16'he000; offs[4] = 16'hf0f0;
    m_known = 1'b0;
    switch = 8'h00;

    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num, 32'h0);

    idle(10);
    rd(32'hbfaf_e000);
    check("timer_10", data_sram_rdata, 32'd10);

    for (int i = 0; i < 16; i++) wr(i * 4, 4'hf, $urandom);

    wr(32'h0000_0100, 4'hf, 32'hdeadbeef);
    rd(32'h0000_0100);
    check("ram_word", data_sram_rdata, 32'hdeadbeef);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("rdata_hold", data_sram_rdata, 32'hdeadbeef);
    end

    wr(32'h0000_0100, 4'b0101, 32'h1122_3344);
    rd(32'h0000_0100);
    check("byte_en", data_sram_rdata, 32'hde22be44);

    wr(32'h0001_0100, 4'hf, 32'h5a5a5a5a);
    rd(32'h0000_0100);
    check("alias", data_sram_rdata, 32'h5a5a5a5a);

    wr(32'hbfaf_f000, 4'hf, 32'hffff_abcd);
    check("led_wr", {16'h0, led}, 32'h0000_abcd);
    rd(32'hbfaf_f000);
    check("led_rd", data_sram_rdata, 32'h0000_abcd);
    wr(32'hbfaf_f010, 4'hf, 32'h12345678);
    check("num_wr", num, 32'h12345678);
    switch = 8'h3c;
    idle(2);
    rd(32'hbfaf_f020);
    check("switch_rd", data_sram_rdata, 32'h0000_003c);
    wr(32'hbfaf_f020, 4'hf, 32'hffff_ffff);
    rd(32'hbfaf_f020);
    check("switch_ro", data_sram_rdata, 32'h0000_003c);
    rd(32'hbfaf_f0f0);
    check("mmio_hole", data_sram_rdata, 32'h0);

    wr(32'hbfaf_e000, 4'hf, 32'hffff_fffe);
    idle(2);
    rd(32'hbfaf_e000);
    check("timer_wrap", data_sram_rdata, 32'h0);

    wr(32'h0000_0200, 4'hf, 32'hcafef00d);
    step(1'b1, 1'b1, 4'hf, 32'h0000_0200, 32'h0);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num, 32'h0);
    rd(32'hbfaf_e000);
    check("rst_timer", data_sram_rdata, 32'h0);
    rd(32'h0000_0200);
    check("rst_ram", data_sram_rdata, 32'hcafef00d);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) switch = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = {16'hbfaf, offs[$urandom_range(0, 4)]};
      end else begin
        hi = 16'($urandom);
        if (hi == 16'hbfaf) hi = 16'h0;
        a = {hi, 10'h0, 4'($urandom), 2'($urandom)};
      end
      d = $urandom;
      case ($urandom_range(0, 9))
        0:       step(1'b1, 1'($urandom), 4'($urandom), a, d);
        1, 2:    step(1'b0, 1'b0, 4'($urandom), a, d);
        3, 4, 5: step(1'b0, 1'b1, 4'($urandom), a, d);
        default: step(1'b0, 1'b1, 4'h0, a, d);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
